// File: rtl/ysyx_24100006_arb_pkg.sv
// Shared types and constants for the IFU/LSU data-memory arbiter.
package ysyx_24100006_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } arb_state_e;

  // Which requester owns the current transaction
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Clears the byte offset so the memory always sees word addresses
  localparam logic [31:0] ALIGN_MASK = ~32'h3;

endpackage

// File: rtl/ysyx_24100006_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// whichever side was not granted last.
module ysyx_24100006_rr_arb2
  import ysyx_24100006_arb_pkg::*;
(
  input  logic   req_ifu,
  input  logic   req_lsu,
  input  owner_e last_grant,
  output logic   gnt_ifu,
  output logic   gnt_lsu
);

  // Grant selection; the two grants are mutually exclusive by construction
  always_comb begin
    gnt_ifu = req_ifu && (!req_lsu || (last_grant == OWN_LSU));
    gnt_lsu = req_lsu && (!req_ifu || (last_grant == OWN_IFU));
  end

endmodule

// File: rtl/ysyx_24100006_mem_arbiter.sv
// Shares one data-memory port between IFU (read-only) and LSU (read/write).
// One transaction at a time: IDLE -> REQ -> WAIT -> RESP (-> DRAIN), with a
// watchdog that turns a missing memory handshake/response into an error reply.
module ysyx_24100006_mem_arbiter
  import ysyx_24100006_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MASK_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic              lsu_we,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  input  logic [MASK_W-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Package mask widened to the address width (upper bits stay set)
  localparam logic [ADDR_W-1:0] ADDR_ALIGN = ~ADDR_W'(~ALIGN_MASK);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              drain_q, drain_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              gnt_ifu, gnt_lsu;
  logic              timeout_hit;

  ysyx_24100006_rr_arb2 u_rr (
    .req_ifu    (ifu_req_valid),
    .req_lsu    (lsu_req_valid),
    .last_grant (last_q),
    .gnt_ifu    (gnt_ifu),
    .gnt_lsu    (gnt_lsu)
  );

  // The current REQ/WAIT cycle is the TIMEOUT-th one spent without progress
  assign timeout_hit = (wdog_q >= CNT_W'(TIMEOUT - 1));

  // Next-state, request latching and watchdog logic
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    drain_d       = drain_q;
    wdog_d        = wdog_q;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ifu_req_ready = gnt_ifu;
        lsu_req_ready = gnt_lsu;
        if (gnt_lsu) begin
          owner_d = OWN_LSU;
          last_d  = OWN_LSU;
          we_d    = lsu_we;
          addr_d  = lsu_addr & ADDR_ALIGN;
          wdata_d = lsu_wdata;
          wmask_d = lsu_wmask;
          wdog_d  = '0;
          state_d = ST_REQ;
        end else if (gnt_ifu) begin
          owner_d = OWN_IFU;
          last_d  = OWN_IFU;
          we_d    = 1'b0;
          addr_d  = ifu_addr & ADDR_ALIGN;
          wdata_d = '0;
          wmask_d = '0;
          wdog_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wdog_q != CNT_W'(TIMEOUT)) wdog_d = wdog_q + 1'b1;
        // An accepted request wins over a simultaneous timeout so the
        // memory's eventual response is never left unaccounted for.
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (wdog_q != CNT_W'(TIMEOUT)) wdog_d = wdog_q + 1'b1;
        if (mem_resp_valid) begin
          rdata_d = we_q ? 32'h0 : mem_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          // Memory still owes a response; swallow it later in DRAIN
          rdata_d = '0;
          err_d   = 1'b1;
          drain_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = drain_q ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (mem_resp_valid) begin
          drain_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched-request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      last_q  <= OWN_IFU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      drain_q <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      drain_q <= drain_d;
      wdog_q  <= wdog_d;
    end
  end

  assign mem_req_valid  = (state_q == ST_REQ);
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign mem_wmask      = wmask_q;
  assign ifu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_IFU);
  assign lsu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_LSU);
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;

endmodule

// File: tb/tb_ysyx_24100006_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: a transaction-level
// model plus a configurable memory responder, with directed scenarios.
module tb_ysyx_24100006_mem_arbiter;

  localparam int   T     = 4;
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_L = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_resp_valid;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic        lsu_we = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0;
  logic [7:0]  lsu_wmask = '0;
  logic        lsu_resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  ysyx_24100006_mem_arbiter #(.ADDR_W(32), .MASK_W(8), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic own; logic we; logic [31:0] addr; logic [31:0] wdata; logic [7:0] wmask;
    logic [31:0] rdata; logic err; logic drain; int hs;
  } txn_t;
  typedef struct { logic [1:0] rv; logic err; logic [31:0] rdata; int lat; logic mrv; } rsp_t;

  txn_t exp_q[$];
  rsp_t resp_log[$];
  int   hs_log[$];
  logic grant_log[$];
  int   checks = 0, errors = 0, cyc = 0;
  logic model_last = OWN_I;
  logic drain_pending = 1'b0;
  int   cfg_rdy = 0, cfg_rsp = 1;
  logic [31:0] cfg_rdata = '0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected outcome of a granted request, from the memory timing it will see
  function automatic txn_t mk(input logic own, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [7:0] wmask);
    txn_t n;
    logic req_to, wait_to;
    n.own   = own;
    n.we    = (own == OWN_I) ? 1'b0 : we;
    n.addr  = addr & 32'hFFFF_FFFC;
    n.wdata = (own == OWN_I) ? 32'h0 : wdata;
    n.wmask = (own == OWN_I) ? 8'h0 : wmask;
    req_to  = (cfg_rdy + 1 > T);
    wait_to = !req_to && ((cfg_rsp == 0) || (cfg_rdy + 1 + cfg_rsp > T));
    n.err   = req_to || wait_to;
    n.drain = wait_to;
    n.rdata = (n.err || n.we) ? 32'h0 : cfg_rdata;
    n.hs    = cyc;
    return n;
  endfunction

  // Compare process: one sample per cycle, just after the falling edge
  initial begin
    logic idle, e_ifu, e_lsu;
    logic [1:0] rv;
    txn_t e;
    rsp_t r;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        chk("reset_ctl", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                          mem_req_valid, mem_we, resp_err, mem_wmask}, '0);
        chk("reset_data", {mem_addr, mem_wdata, resp_rdata}, '0);
        exp_q.delete();
        drain_pending = 1'b0;
        model_last = OWN_I;
      end else begin
        idle  = (exp_q.size() == 0) && !drain_pending;
        e_ifu = idle && ifu_req_valid && (!lsu_req_valid || model_last == OWN_L);
        e_lsu = idle && lsu_req_valid && (!ifu_req_valid || model_last == OWN_I);
        chk("req_ready", {ifu_req_ready, lsu_req_ready}, {e_ifu, e_lsu});
        if (mem_req_valid) begin
          if (exp_q.size() == 0) chk("mem_req_unexpected", mem_req_valid, 1'b0);
          else chk("mem_req_fields", {mem_we, mem_wmask, mem_addr, mem_wdata},
                   {exp_q[0].we, exp_q[0].wmask, exp_q[0].addr, exp_q[0].wdata});
        end
        if (drain_pending && mem_resp_valid) drain_pending = 1'b0;
        rv = {ifu_resp_valid, lsu_resp_valid};
        if (rv != 2'b00) begin
          if (exp_q.size() == 0) chk("resp_unexpected", rv, 2'b00);
          else begin
            e = exp_q.pop_front();
            chk("resp_owner", rv, (e.own == OWN_L) ? 2'b01 : 2'b10);
            chk("resp_data", {resp_err, resp_rdata}, {e.err, e.rdata});
            drain_pending = e.drain;
            r.rv = rv; r.err = resp_err; r.rdata = resp_rdata; r.lat = cyc - e.hs;
            r.mrv = mem_req_valid;
            resp_log.push_back(r);
          end
        end
        if (ifu_req_valid && ifu_req_ready) begin
          exp_q.push_back(mk(OWN_I, 1'b0, ifu_addr, 32'h0, 8'h0));
          model_last = OWN_I; grant_log.push_back(OWN_I); hs_log.push_back(cyc);
        end else if (lsu_req_valid && lsu_req_ready) begin
          exp_q.push_back(mk(OWN_L, lsu_we, lsu_addr, lsu_wdata, lsu_wmask));
          model_last = OWN_L; grant_log.push_back(OWN_L); hs_log.push_back(cyc);
        end
      end
    end
  end

  // Memory responder: ready after cfg_rdy REQ cycles, response cfg_rsp cycles
  // after acceptance (0 = never). Timing is snapshotted on the first REQ cycle.
  initial begin
    int req_cycles, resp_cnt, cur_rdy, cur_rsp;
    logic [31:0] cur_rdata, pend_rdata;
    req_cycles = 0; resp_cnt = 0; cur_rdy = 0; cur_rsp = 0;
    cur_rdata = '0; pend_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (!rst_n) begin
        mem_req_ready = 1'b0; req_cycles = 0; resp_cnt = 0;
      end else begin
        if (mem_req_ready) begin
          mem_req_ready = 1'b0; req_cycles = 0;
          resp_cnt = cur_rsp; pend_rdata = cur_rdata;
        end else if (mem_req_valid) begin
          if (req_cycles == 0) begin
            cur_rdy = cfg_rdy; cur_rsp = cfg_rsp; cur_rdata = cfg_rdata;
          end
          if (req_cycles == cur_rdy) mem_req_ready = 1'b1;
          req_cycles++;
        end else begin
          req_cycles = 0;
        end
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            mem_resp_valid = 1'b1; mem_rdata = pend_rdata;
          end
        end
      end
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_logs();
    resp_log.delete(); hs_log.delete(); grant_log.delete();
  endtask

  task automatic issue(input logic own, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [7:0] wmask,
                       input int rdy, input int rsp, input logic [31:0] rdata);
    logic got;
    got = 1'b0;
    @(negedge clk);
    cfg_rdy = rdy; cfg_rsp = rsp; cfg_rdata = rdata;
    if (own == OWN_I) begin
      ifu_req_valid = 1'b1; ifu_addr = addr;
    end else begin
      lsu_req_valid = 1'b1; lsu_we = we; lsu_addr = addr;
      lsu_wdata = wdata; lsu_wmask = wmask;
    end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if ((own == OWN_I) ? ifu_req_ready : lsu_req_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk("issue_accept", got, 1'b1);
    @(negedge clk);
    if (own == OWN_I) ifu_req_valid = 1'b0;
    else lsu_req_valid = 1'b0;
  endtask

  task automatic wait_done();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0 && !drain_pending) begin
        ok = 1'b1;
        break;
      end
    end
    chk("txn_complete", ok, 1'b1);
  endtask

  task automatic chk_resp(input string nm, input int idx, input logic [1:0] rv,
                          input logic err, input logic [31:0] rdata, input int lat);
    if (resp_log.size() > idx) begin
      chk({nm, "_owner"}, resp_log[idx].rv, rv);
      chk({nm, "_data"}, {resp_log[idx].err, resp_log[idx].rdata}, {err, rdata});
      if (lat >= 0) chk({nm, "_latency"}, resp_log[idx].lat, lat);
      chk({nm, "_memvalid"}, resp_log[idx].mrv, 1'b0);
    end else begin
      chk({nm, "_missing"}, resp_log.size(), idx + 1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [95:0] snap;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("post_reset_outputs", {resp_rdata, mem_addr, resp_err, mem_req_valid}, '0);

    // IFU read from an unaligned address; response 2 cycles after accept
    clear_logs();
    issue(OWN_I, 1'b0, 32'h8000_0006, 32'h0, 8'h0, 0, 2, 32'hDEAD_BEEF);
    #2;
    chk("ifu_mem_fields", {mem_we, mem_addr}, {1'b0, 32'h8000_0004});
    wait_done();
    chk_resp("ifu_read", 0, 2'b10, 1'b0, 32'hDEAD_BEEF, 4);

    // LSU write; memory takes one extra cycle to accept
    clear_logs();
    issue(OWN_L, 1'b1, 32'h8000_0010, 32'h1234_5678, 8'h0F, 1, 1, 32'hFFFF_FFFF);
    #2;
    chk("lsu_mem_fields", {mem_we, mem_wmask, mem_addr, mem_wdata},
        {1'b1, 8'h0F, 32'h8000_0010, 32'h1234_5678});
    wait_done();
    chk_resp("lsu_write", 0, 2'b01, 1'b0, 32'h0, 4);

    // Both requesters held valid from reset: strict alternation, LSU first
    reset_dut();
    clear_logs();
    cfg_rdy = 0; cfg_rsp = 1; cfg_rdata = 32'hA5A5_0001;
    @(negedge clk);
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0102;
    lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0000_0204;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (grant_log.size() >= 4) break;
    end
    @(negedge clk);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    wait_done();
    chk("grant_count", grant_log.size() >= 4, 1'b1);
    if (grant_log.size() >= 4) begin
      chk("grant_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]},
          {OWN_L, OWN_I, OWN_L, OWN_I});
      chk("grant_spacing", hs_log[1] - hs_log[0], 4);
    end

    // Response withheld past the watchdog: error, then late pulse drained
    clear_logs();
    issue(OWN_L, 1'b0, 32'h8000_0022, 32'h0, 8'h0, 0, 7, 32'h1111_1111);
    issue(OWN_I, 1'b0, 32'h8000_0104, 32'h0, 8'h0, 0, 1, 32'hCAFE_F00D);
    wait_done();
    chk_resp("wait_timeout", 0, 2'b01, 1'b1, 32'h0, 5);
    chk_resp("after_drain", 1, 2'b10, 1'b0, 32'hCAFE_F00D, 3);
    if (hs_log.size() >= 2) chk("drain_hold_cycles", hs_log[1] - hs_log[0], 9);
    else chk("drain_hs_missing", hs_log.size(), 2);

    // mem_req_ready never comes: error after TIMEOUT REQ cycles, no drain
    clear_logs();
    issue(OWN_I, 1'b0, 32'h8000_0300, 32'h0, 8'h0, 100, 1, 32'h0);
    issue(OWN_L, 1'b0, 32'h8000_0400, 32'h0, 8'h0, 0, 1, 32'h0BAD_CAFE);
    wait_done();
    chk_resp("req_timeout", 0, 2'b10, 1'b1, 32'h0, 5);
    chk_resp("after_req_timeout", 1, 2'b01, 1'b0, 32'h0BAD_CAFE, 3);
    if (hs_log.size() >= 2) chk("no_drain_cycles", hs_log[1] - hs_log[0], 6);
    else chk("req_to_hs_missing", hs_log.size(), 2);

    // Reset while waiting on memory: outputs clear at once, nothing replied
    clear_logs();
    issue(OWN_I, 1'b0, 32'h8000_0500, 32'h0, 8'h0, 0, 0, 32'h0);
    @(negedge clk);
    #3;
    snap = {dut.mem_addr, 32'h0, 32'h0};
    chk("wait_before_reset", snap[95:64], 32'h8000_0500);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {ifu_resp_valid, lsu_resp_valid, mem_req_valid, mem_we,
                                resp_err, mem_addr, resp_rdata}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(OWN_I, 1'b0, 32'h8000_0203, 32'h0, 8'h0, 0, 1, 32'h55AA_55AA);
    wait_done();
    chk_resp("post_reset_read", 0, 2'b10, 1'b0, 32'h55AA_55AA, 3);
    chk("aborted_no_resp", resp_log.size(), 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
